// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, credit-limited request channel to
// instruction memory, DEPTH-entry prefetch FIFO toward the decoder, redirect flush.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4,
    parameter int              ADDR_W   = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [XLEN-1:0]   inst_pc,
    output logic              misalign_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] head_pc_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   drop_cnt_reg;
    logic            misalign_err_reg;
    logic [31:0]     fifo_mem [DEPTH];

    logic [CW:0]     in_use;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            drop_rsp;
    logic [XLEN-1:0] redirect_target;

    assign in_use          = {1'b0, count_reg} + {1'b0, outstanding_reg};
    assign imem_req_valid  = !rst && !redirect_valid && (in_use < (CW+1)'(DEPTH));
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign imem_req_addr   = fetch_pc_reg[ADDR_W+1:2];

    // A response is kept only if no redirect is flushing it now or earlier.
    assign push            = imem_rsp_valid && !redirect_valid && (drop_cnt_reg == '0);
    assign drop_rsp        = imem_rsp_valid && !redirect_valid && (drop_cnt_reg != '0);
    assign pop             = inst_valid && inst_ready && !redirect_valid;
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    assign inst_valid      = (count_reg != '0);
    assign inst_data       = fifo_mem[rd_ptr_reg];
    assign inst_pc         = head_pc_reg;
    assign misalign_err    = misalign_err_reg;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc_reg[XLEN-1:ADDR_W+2], fetch_pc_reg[1:0]};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg     <= RESET_PC;
            head_pc_reg      <= RESET_PC;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            outstanding_reg  <= '0;
            drop_cnt_reg     <= '0;
            misalign_err_reg <= 1'b0;
        end else begin
            outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc_reg <= redirect_target;
                head_pc_reg  <= redirect_target;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                count_reg    <= '0;
                // Everything still in flight after this cycle belongs to the old path.
                drop_cnt_reg <= outstanding_reg - CW'(imem_rsp_valid);
                if (redirect_pc[1:0] != 2'b00) begin
                    misalign_err_reg <= 1'b1;
                end
            end else begin
                if (req_fire) begin
                    fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
                end
                if (pop) begin
                    head_pc_reg <= head_pc_reg + XLEN'(4);
                    rd_ptr_reg  <= rd_ptr_reg + PW'(1);
                end
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (drop_rsp) begin
                    drop_cnt_reg <= drop_cnt_reg - CW'(1);
                end
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit: an in-order latency memory drives
// the DUT while a queue-based reference model predicts every output each cycle.
module tb_fetch_unit;
    localparam int XLEN   = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              redirect_valid = 1'b0;
    logic [XLEN-1:0]   redirect_pc = '0;
    logic              imem_req_valid;
    logic              imem_req_ready = 1'b0;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid = 1'b0;
    logic [31:0]       imem_rsp_data = '0;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic [31:0]       inst_data;
    logic [XLEN-1:0]   inst_pc;
    logic              misalign_err;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .misalign_err(misalign_err)
    );

    int total = 0;
    int bad   = 0;

    typedef struct { logic [31:0] pc; int epoch; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic [ADDR_W-1:0] addr; int due; } mreq_t;

    // reference model: path epoch identifies responses a redirect has orphaned
    logic [31:0] m_fetch;
    infl_t       m_infl[$];
    ent_t        m_fifo[$];
    bit          m_mis;
    int          m_epoch;

    mreq_t mq[$];
    int    last_due;
    int    cyc = 0;
    int    n_hs = 0;
    int    n_pop = 0;

    bit          d_rst = 1'b1, d_redir = 1'b0, d_iready = 1'b0, d_rready = 1'b0;
    logic [31:0] d_rpc = '0;
    int          lat_lo = 1, lat_hi = 1;

    function automatic logic [31:0] mem_fn(input logic [ADDR_W-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%08h required=%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_fetch = 32'h0;
        m_infl.delete();
        m_fifo.delete();
        m_mis = 1'b0;
        m_epoch = 0;
        mq.delete();
        last_due = cyc;
        n_hs = 0;
    endtask

    task automatic step();
        bit    exp_rv;
        bit    rsp;
        bit    keep;
        infl_t e;
        int    due;
        @(negedge clk);
        rst            = d_rst;
        redirect_valid = d_redir;
        redirect_pc    = d_rpc;
        inst_ready     = d_iready;
        imem_req_ready = d_rready;
        rsp = 1'b0;
        if (!d_rst && mq.size() > 0 && mq[0].due <= cyc) begin
            rsp = 1'b1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_fn(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        exp_rv = !d_rst && !d_redir && (m_fifo.size() + m_infl.size() < DEPTH);
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (!d_rst) begin
            check("req_addr", 32'(imem_req_addr), 32'(m_fetch[ADDR_W+1:2]));
            check("inst_valid", 32'(inst_valid), 32'(m_fifo.size() > 0));
            if (m_fifo.size() > 0) begin
                check("inst_pc", inst_pc, m_fifo[0].pc);
                check("inst_data", inst_data, m_fifo[0].data);
            end
            check("misalign_err", 32'(misalign_err), 32'(m_mis));
        end
        // memory side follows the DUT's actual handshake
        if (!d_rst && imem_req_valid && d_rready) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: imem_req_addr, due: due});
            n_hs++;
        end
        if (d_rst) begin
            model_reset();
        end else begin
            keep = 1'b0;
            if (rsp) begin
                check("rsp_in_flight", 32'(m_infl.size() != 0), 32'd1);
                if (m_infl.size() != 0) begin
                    e = m_infl.pop_front();
                    keep = !d_redir && (e.epoch == m_epoch);
                end
            end
            if (!d_redir && d_iready && m_fifo.size() > 0) begin
                $display("pop pc=%08h data=%08h", m_fifo[0].pc, m_fifo[0].data);
                void'(m_fifo.pop_front());
                n_pop++;
            end
            if (keep) m_fifo.push_back('{pc: e.pc, data: mem_fn(e.pc[ADDR_W+1:2])});
            if (d_redir) begin
                m_fifo.delete();
                m_epoch++;
                m_fetch = {d_rpc[31:2], 2'b00};
                if (d_rpc[1:0] != 2'b00) m_mis = 1'b1;
            end else if (exp_rv && d_rready) begin
                m_infl.push_back('{pc: m_fetch, epoch: m_epoch});
                m_fetch = m_fetch + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        int n;
        n = 0;
        while (!inst_valid && n < 30) begin
            step();
            n++;
        end
        check({name, "_timeout"}, 32'(inst_valid), 32'd1);
        check(name, inst_pc, exp_pc);
    endtask

    initial begin
        model_reset();
        // reset and first fetches with 1-cycle memory
        d_rst = 1; d_rready = 1; d_iready = 1; lat_lo = 1; lat_hi = 1;
        step(); step();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        d_rst = 0;
        step();
        check("first_addr_adv", 32'(imem_req_addr), 32'd1);
        check("first_not_valid", 32'(inst_valid), 32'd0);
        step();
        check("first_valid", 32'(inst_valid), 32'd1);
        check("first_pc", inst_pc, 32'h0);
        check("first_data", inst_data, 32'hA5A5_0F0F);
        step();
        check("second_pc", inst_pc, 32'h4);

        // decoder stalled: credit limit stops issue after DEPTH requests
        d_rst = 1; step();
        d_rst = 0; d_iready = 0;
        repeat (8) step();
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_hs_count", 32'(n_hs), 32'd4);
        check("stall_head_pc", inst_pc, 32'h0);
        check("stall_fetch_addr", 32'(imem_req_addr), 32'd4);
        d_iready = 1; step();
        check("resume_head_pc", inst_pc, 32'h4);

        // redirect with slow memory so responses are in flight
        lat_lo = 3; lat_hi = 3;
        step(); step();
        d_redir = 1; d_rpc = 32'h100; step();
        check("redir_flush", 32'(inst_valid), 32'd0);
        check("redir_addr", 32'(imem_req_addr), 32'h40);
        d_redir = 0;
        wait_valid("redir_first_pc", 32'h100);

        // misaligned then back-to-back aligned redirect
        d_redir = 1; d_rpc = 32'h103; step();
        check("mis_set", 32'(misalign_err), 32'd1);
        check("mis_addr", 32'(imem_req_addr), 32'h40);
        d_rpc = 32'h200; step();
        check("mis_sticky", 32'(misalign_err), 32'd1);
        check("b2b_addr", 32'(imem_req_addr), 32'h80);
        d_redir = 0;
        wait_valid("b2b_first_pc", 32'h200);

        // randomized traffic
        lat_lo = 1; lat_hi = 3;
        n_pop = 0;
        for (int i = 0; i < 20000 && n_pop < 1000; i++) begin
            d_rst    = ($urandom % 600) == 0;
            d_rready = ($urandom % 4) != 0;
            d_iready = ($urandom % 3) != 0;
            d_redir  = ($urandom % 40) == 0;
            d_rpc    = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step();
        end
        check("random_pops", 32'(n_pop >= 1000), 32'd1);

        // reset clears sticky misalignment
        d_rst = 0; d_redir = 1; d_rpc = 32'h1; step();
        check("mis_before_rst", 32'(misalign_err), 32'd1);
        d_redir = 0; d_rst = 1; step();
        d_rst = 0; step();
        check("mis_after_rst", 32'(misalign_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
